// File: rtl/mm_reg_bank.sv
// Avalon-MM register bank: DEPTH-1 byte-enabled control registers plus a sticky
// status register (hardware sets, bus clears by read or write-1-to-clear), fixed read latency.
module mm_reg_bank #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 2,
  parameter int RD_LAT = 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [ADDR_W-1:0]             i_address,
  input  logic                          i_read,
  input  logic                          i_write,
  input  logic [WIDTH-1:0]              i_writedata,
  input  logic [WIDTH/8-1:0]            i_byteenable,
  output logic [WIDTH-1:0]              o_readdata,
  output logic                          o_readdatavalid,
  output logic                          o_waitrequest,
  input  logic [WIDTH-1:0]              i_sts_in,
  output logic [(2**ADDR_W)*WIDTH-1:0]  o_reg_out
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = WIDTH/8;
  localparam logic [ADDR_W-1:0] STS_ADDR = ADDR_W'(DEPTH-1);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;

  logic [DEPTH-1:0][WIDTH-1:0]  r_regs;
  logic [RD_LAT-1:0]            r_vld_pipe;
  logic [RD_LAT-1:0][WIDTH-1:0] r_dat_pipe;

  logic             w_wr_acc, w_rd_acc;
  logic [WIDTH-1:0] w_wmask, w_sts_clr;

  assign o_waitrequest = (r_state == BUSY);
  // Write wins a read/write collision; the read is simply dropped.
  assign w_wr_acc = i_write & ~o_waitrequest;
  assign w_rd_acc = i_read & ~i_write & ~o_waitrequest;

  always_comb begin
    w_wmask = '0;
    for (int k = 0; k < NB; k++) w_wmask[8*k +: 8] = {8{i_byteenable[k]}};
  end

  // A status read clears exactly the bits it returns.
  always_comb begin
    w_sts_clr = '0;
    if (w_wr_acc && i_address == STS_ADDR)      w_sts_clr = i_writedata & w_wmask;
    else if (w_rd_acc && i_address == STS_ADDR) w_sts_clr = r_regs[DEPTH-1];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_regs <= '0;
    end else begin
      for (int r = 0; r < DEPTH-1; r++)
        if (w_wr_acc && i_address == ADDR_W'(r))
          r_regs[r] <= (r_regs[r] & ~w_wmask) | (i_writedata & w_wmask);
      r_regs[DEPTH-1] <= (r_regs[DEPTH-1] & ~w_sts_clr) | i_sts_in;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: if (w_rd_acc && (RD_LAT > 1)) begin
        w_state_nxt = BUSY;
        w_cnt_nxt   = 3'(RD_LAT-1);
      end
      BUSY: begin
        w_cnt_nxt = r_cnt - 3'd1;
        if (r_cnt == 3'd1) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Data stages only load behind a valid, so the last stage holds readdata between pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld_pipe <= '0;
      r_dat_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= w_rd_acc;
      if (w_rd_acc) r_dat_pipe[0] <= r_regs[i_address];
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        if (r_vld_pipe[i-1]) r_dat_pipe[i] <= r_dat_pipe[i-1];
      end
    end
  end

  assign o_readdatavalid = r_vld_pipe[RD_LAT-1];
  assign o_readdata      = r_dat_pipe[RD_LAT-1];
  assign o_reg_out       = r_regs;

endmodule

// File: doc/mm_reg_bank.md
# mm_reg_bank

Memory-mapped register bank: the bus-facing read/write responder that owns a set of width-bit write-enabled registers and returns their contents to a bus master. It sits between the Nios Avalon-MM fabric and fabric-side logic. Control registers are exported flat to hardware. The top register is a sticky status register: hardware sets bits, the bus clears them by read or by write-1-to-clear. Reads complete with a fixed, parameterised latency and apply backpressure via waitrequest.

## Interface
- width, 32, data width; multiple of 8
- addr_w, 2, address width; depth = 2**addr_w registers
- rd_lat, 1, read latency in cycles, legal 1..4
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- address  in  addr_w  register index
- read  in  1  read request
- write  in  1  write request
- writedata  in  width  write data
- byteenable  in  width/8  byte lane enables for writes
- readdata  out  width  read data
- readdatavalid  out  1  one-cycle pulse, readdata valid
- waitrequest  out  1  request not accepted this cycle
- sts_in  in  width  status event bits, OR-ed into status register each cycle
- reg_out  out  depth*width  all register contents; register i at bits [i*width +: width]

## Operation
- Registers 0..depth-2: control, read/write. Register depth-1: status (STS).
- Accept rule: a request is accepted in a cycle where (read or write) and waitrequest=0.
- Write wins: read and write both high -> write performed, read dropped, no readdatavalid.
- Control write: byte lane k updated from writedata[8k+7:8k] only if byteenable[k]=1; other lanes hold.
- STS write (W1C): mask = writedata with disabled lanes zeroed; STS_next = (STS & ~mask) | sts_in.
- STS read: returns STS as registered in the accept cycle (excludes that cycle's sts_in); STS_next = (STS & ~returned_value) | sts_in.
- Idle cycles: STS_next = STS | sts_in. sts_in always has priority over clear; an event in the clear cycle is never lost.
- Read data is captured in the accept cycle from the registered value, then carried down the latency pipeline.
- FSM: IDLE -> BUSY on accepted read when rd_lat>1; BUSY counts down rd_lat-1 cycles -> IDLE. rd_lat=1 never enters BUSY.
- waitrequest = (state == BUSY). Writes and reads presented while BUSY are held off and not performed.
- readdata holds its last value between pulses.

## Timing
- Reset (rstn=0, async): all registers 0, reg_out 0, readdata 0, readdatavalid 0, waitrequest 0, FSM IDLE, pipeline flushed.
- Reset mid-read: the in-flight read is discarded; no readdatavalid after release.
- Write accepted at cycle T: register and reg_out updated at T+1.
- Read accepted at T: readdatavalid=1 and readdata valid at T+rd_lat, for one cycle; waitrequest=1 for T+1..T+rd_lat-1; a new request can be accepted at T+rd_lat.
- rd_lat=1: one read accepted per cycle, back-to-back, valid each following cycle.
- Read-after-write to the same register in consecutive cycles returns the new value.
- STS clear from a read takes effect at T+1, independent of rd_lat.

## Test plan
- Reset: drive random bus inputs, pulse rstn low mid-read with rd_lat=3 -> all outputs 0, no readdatavalid after release.
- Byte enables: write 0xAABBCCDD to reg 0 with byteenable=4'b0101 from 0 -> reg_out[31:0]=0x00BB00DD at T+1; read returns 0x00BB00DD.
- Latency/backpressure, rd_lat=3: read reg 1 at T -> waitrequest high T+1..T+2, valid at T+3; a write held from T+1 is accepted at T+3 only.
- Status read-clear: sts_in=0x5 one cycle, then read STS while sts_in=0x2 -> readdata=0x5, STS=0x2 afterwards; next read returns 0x2.
- W1C with concurrent event: STS=0xF, write 0x3 with sts_in=0x1 -> STS=0xD.
- Collision and throughput, rd_lat=1: read+write together to reg 0 -> write done, no readdatavalid; then 4 back-to-back reads of regs 0..3 -> 4 consecutive valid pulses in order.
